// File: rtl/shutter_pkg.sv
// Shared definitions for the LCD shutter-glasses driver: state encoding,
// default timing parameters and the per-lens plate drive helper.
package shutter_pkg;

    typedef enum logic [1:0] {
        FAILSAFE = 2'd0,
        OPEN_R   = 2'd1,
        DEAD     = 2'd2,
        OPEN_L   = 2'd3
    } shutter_state_e;

    localparam int unsigned DEAD_TICKS_DEF = 1;
    localparam int unsigned POL_TICKS_DEF  = 8;
    localparam int unsigned WDOG_TICKS_DEF = 50;

    // An open lens sees no field across its plates; a closed lens sees the full swing.
    function automatic logic [1:0] lens_drive(input logic open, input logic pol);
        return open ? {pol, pol} : {pol, ~pol};
    endfunction

endpackage

// File: rtl/pol_gen.sv
// LCD drive polarity generator: flips pol every POL_TICKS ticks so the
// liquid crystal never sees a DC bias; clear holds it idle at pol=0.
module pol_gen
    import shutter_pkg::*;
#(
    parameter int unsigned POL_TICKS = POL_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    output logic pol
);

    localparam int unsigned CW = $clog2(POL_TICKS) + 1;
    localparam logic [CW-1:0] POL_LIM = CW'(POL_TICKS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pol_q, pol_d;

    always_comb begin
        cnt_d = cnt_q;
        pol_d = pol_q;
        if (clear) begin
            cnt_d = '0;
            pol_d = 1'b0;
        end else if (tick) begin
            if (cnt_q + CW'(1) == POL_LIM) begin
                cnt_d = '0;
                pol_d = ~pol_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pol_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pol_q <= pol_d;
        end
    end

    assign pol = pol_q;

endmodule

// File: rtl/shutter_driver.sv
// Shutter-glasses lens driver: eye-swap FSM with dead time and registered plate drives.
// Define SHUTTER_WATCHDOG_EN to drop to FAILSAFE when no swap arrives for WDOG_TICKS ticks.
module shutter_driver
    import shutter_pkg::*;
#(
    parameter int unsigned DEAD_TICKS = DEAD_TICKS_DEF,
    parameter int unsigned POL_TICKS  = POL_TICKS_DEF,
    parameter int unsigned WDOG_TICKS = WDOG_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       l_right,
    input  logic       l_left,
    input  logic       error,
    output logic       r_a,
    output logic       r_b,
    output logic       l_a,
    output logic       l_b,
    output logic [1:0] state
);

    localparam int unsigned DW = $clog2(DEAD_TICKS) + 1;
    localparam logic [DW-1:0] DEAD_LIM = DW'(DEAD_TICKS);

    shutter_state_e state_q, state_d;
    logic [DW-1:0]  dead_q, dead_d;
    logic [3:0]     plates_q, plates_d;
    logic           pol;
    logic           pol_clear;

`ifdef SHUTTER_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG_TICKS) + 1;
    localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_TICKS);
    logic [WW-1:0] wdog_q, wdog_d;
`endif

    // error wins on any clk; otherwise decisions are taken only on ticks.
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
`ifdef SHUTTER_WATCHDOG_EN
        wdog_d  = wdog_q;
`endif
        if (error) begin
            state_d = FAILSAFE;
        end else if (tick) begin
            if (state_q != FAILSAFE && l_right == l_left) begin
                state_d = FAILSAFE;
            end else begin
                case (state_q)
                    FAILSAFE: if (l_right != l_left) state_d = DEAD;
                    OPEN_R: begin
                        if (!l_right) begin
                            state_d = DEAD;
                        end
`ifdef SHUTTER_WATCHDOG_EN
                        else begin
                            wdog_d = wdog_q + WW'(1);
                            if (wdog_d == WDOG_LIM) state_d = FAILSAFE;
                        end
`endif
                    end
                    OPEN_L: begin
                        if (l_right) begin
                            state_d = DEAD;
                        end
`ifdef SHUTTER_WATCHDOG_EN
                        else begin
                            wdog_d = wdog_q + WW'(1);
                            if (wdog_d == WDOG_LIM) state_d = FAILSAFE;
                        end
`endif
                    end
                    DEAD: begin
                        if (dead_q + DW'(1) == DEAD_LIM) begin
                            state_d = l_right ? OPEN_R : OPEN_L;
                        end else begin
                            dead_d = dead_q + DW'(1);
                        end
                    end
                    default: state_d = FAILSAFE;
                endcase
            end
        end
        // Every state entry starts its tick counters from zero.
        if (state_d != state_q) begin
            dead_d = '0;
`ifdef SHUTTER_WATCHDOG_EN
            wdog_d = '0;
`endif
        end
    end

    always_comb begin
        plates_d = 4'b0000;
        case (state_q)
            OPEN_R:  plates_d = {lens_drive(1'b1, pol), lens_drive(1'b0, pol)};
            DEAD:    plates_d = {lens_drive(1'b0, pol), lens_drive(1'b0, pol)};
            OPEN_L:  plates_d = {lens_drive(1'b0, pol), lens_drive(1'b1, pol)};
            default: plates_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FAILSAFE;
            dead_q   <= '0;
            plates_q <= 4'b0000;
`ifdef SHUTTER_WATCHDOG_EN
            wdog_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dead_q   <= dead_d;
            plates_q <= plates_d;
`ifdef SHUTTER_WATCHDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    // Hold polarity at 0 on FAILSAFE entry as well as while in it.
    assign pol_clear = (state_q == FAILSAFE) || (state_d == FAILSAFE);

    pol_gen #(
        .POL_TICKS (POL_TICKS)
    ) u_pol_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .clear (pol_clear),
        .pol   (pol)
    );

    assign {r_a, r_b, l_a, l_b} = plates_q;
    assign state = state_q;

endmodule

// File: tb/tb_shutter_driver.sv
// Directed self-checking bench for shutter_driver (DEAD_TICKS=1, POL_TICKS=8, WDOG_TICKS=50).
module tb_shutter_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       l_right;
    logic       l_left;
    logic       error;
    logic       r_a, r_b, l_a, l_b;
    logic [1:0] state;
    logic [3:0] plates;

    int checks   = 0;
    int failures = 0;

    assign plates = {r_a, r_b, l_a, l_b};

    shutter_driver #(
        .DEAD_TICKS (1),
        .POL_TICKS  (8),
        .WDOG_TICKS (50)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .l_right (l_right),
        .l_left  (l_left),
        .error   (error),
        .r_a     (r_a),
        .r_b     (r_b),
        .l_a     (l_a),
        .l_b     (l_b),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one clk with the given inputs; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic t, input logic lr, input logic ll, input logic err);
        tick    = t;
        l_right = lr;
        l_left  = ll;
        error   = err;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic expPol;
        rst_n   = 1'b0;
        tick    = 1'b0;
        l_right = 1'b1;
        l_left  = 1'b0;
        error   = 1'b0;
        #12;
        checkOutput("reset_state", {6'd0, state}, 8'd0);
        checkOutput("reset_plates", {4'd0, plates}, 8'h00);
        rst_n = 1'b1;
        idle(1);

        // Leave FAILSAFE through DEAD into OPEN_L
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("fs_to_dead", {6'd0, state}, 8'd2);
        idle(1);
        checkOutput("dead_plates", {4'd0, plates}, 8'b0101);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("dead_to_open_l", {6'd0, state}, 8'd3);
        idle(1);
        checkOutput("open_l_plates_k1", {4'd0, plates}, 8'b0100);

        // Polarity: ticks counted from leaving FAILSAFE, toggles at 8 and 16
        for (int k = 2; k <= 20; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("hold_l_state_k%0d", k), {6'd0, state}, 8'd3);
            idle(1);
            expPol = (k >= 8) && (k < 16);
            checkOutput($sformatf("hold_l_plates_k%0d", k), {4'd0, plates},
                        {4'd0, expPol, ~expPol, expPol, expPol});
            checkOutput($sformatf("hold_l_r_closed_k%0d", k), {7'd0, r_a ^ r_b}, 8'd1);
        end

        // Swap L -> DEAD -> R, then R -> DEAD -> L
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("open_l_to_dead", {6'd0, state}, 8'd2);
        idle(1);
        checkOutput("dead_plates_2", {4'd0, plates}, 8'b0101);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("dead_to_open_r", {6'd0, state}, 8'd1);
        idle(1);
        checkOutput("open_r_plates", {4'd0, plates}, 8'b0001);
        l_right = 1'b0;
        l_left  = 1'b1;
        idle(1);
        checkOutput("no_tick_no_swap", {6'd0, state}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("open_r_to_dead", {6'd0, state}, 8'd2);
        idle(1);
        checkOutput("swap_all_closed", {4'd0, plates}, 8'b0101);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("swap_open_l", {6'd0, state}, 8'd3);
        idle(1);
        checkOutput("open_l_pol1_plates", {4'd0, plates}, 8'b1011);

        // Illegal input l_right==l_left, and recovery only via DEAD
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("illegal_to_fs", {6'd0, state}, 8'd0);
        idle(1);
        checkOutput("illegal_plates", {4'd0, plates}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("fs_hold_illegal", {6'd0, state}, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("recover_via_dead", {6'd0, state}, 8'd2);
        idle(1);
        checkOutput("recover_plates", {4'd0, plates}, 8'b0101);

        // Error coinciding with a swap tick wins
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("err_prio_state", {6'd0, state}, 8'd0);
        checkOutput("err_prio_plates_lag", {4'd0, plates}, 8'b0101);
        idle(1);
        checkOutput("err_prio_plates", {4'd0, plates}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("reach_open_r", {6'd0, state}, 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("err_no_tick", {6'd0, state}, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("err_blocks_exit", {6'd0, state}, 8'd0);

        // Asynchronous reset in the middle of OPEN_R
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("pre_reset_plates", {4'd0, plates}, 8'b0001);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_state", {6'd0, state}, 8'd0);
        checkOutput("async_reset_plates", {4'd0, plates}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_dead", {6'd0, state}, 8'd2);

        // Hold OPEN_R without any swap
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("wdog_enter_open_r", {6'd0, state}, 8'd1);
        for (int k = 1; k <= 49; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("wdog_49_holds", {6'd0, state}, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SHUTTER_WATCHDOG_EN
        checkOutput("wdog_50_failsafe", {6'd0, state}, 8'd0);
`else
        checkOutput("no_wdog_50_holds", {6'd0, state}, 8'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
